// File: rtl/mdio_pkg.sv
// mdio_pkg -- shared definitions for the MDIO management controller.
//   state_t       : controller FSM states (PREAMBLE exists only when the
//                   MDIO_PREAMBLE_EN macro is defined)
//   OP_WRITE      : opcode value that selects a write frame
//   field bits    : positions of the OP field inside the 32-bit frame word
//   widths/counts : frame, data and per-state bit counter terminal values
package mdio_pkg;

  localparam int FRAME_W  = 32;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 6;

  // Frame word layout: [31:30] ST, [29:28] OP, [27:23] PHYADDR,
  // [22:18] REGADDR, [17:16] TA, [15:0] write data.
  localparam int ST_HI    = 31;
  localparam int OP_HI    = 29;
  localparam int OP_LO    = 28;
  localparam int HDR_BITS = 14;   // bits [31:18] driven during a read
  localparam int TA_BITS  = 2;

  localparam logic [1:0] OP_WRITE = 2'b01;

  // Counter load values: each state counts down to zero, one step per MDC period.
  localparam logic [CNT_W-1:0] CNT_PRE   = 6'd31;
  localparam logic [CNT_W-1:0] CNT_WRITE = 6'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_HDR   = 6'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_TA    = 6'(TA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_DATA  = 6'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
`ifdef MDIO_PREAMBLE_EN
    ST_PREAMBLE = 3'd1,
`endif
    ST_DRIVE    = 3'd2,
    ST_TURN     = 3'd3,
    ST_CAPTURE  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen -- MDC generator (CLK/2) with edge strobes.
//   clk      : system clock
//   reset    : synchronous, active-low
//   en       : run MDC; when low MDC is forced to 0
//   mdc      : management clock output
//   mdc_rise : high in the cycle whose closing CLK edge takes MDC 0->1
//   mdc_fall : high in the cycle whose closing CLK edge takes MDC 1->0
module mdio_clk_gen (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic mdc,
  output logic mdc_rise,
  output logic mdc_fall
);

  logic mdc_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mdc_reg <= 1'b0;
    end else begin
      mdc_reg <= en ? ~mdc_reg : 1'b0;
    end
  end

  // Strobes look ahead one edge so the FSM acts on the same edge that moves MDC.
  assign mdc_rise = en & ~mdc_reg;
  assign mdc_fall = en &  mdc_reg;
  assign mdc      = mdc_reg;

endmodule

// File: rtl/mdio_controller.sv
// mdio_controller -- MDIO (clause 22 style) management frame master.
//   CLK        : system clock, rising edge
//   RESET      : synchronous, active-low
//   MDIO_START : one-cycle launch request, honoured only in IDLE
//   T_DATA     : 32-bit frame word (ST, OP, PHYADDR, REGADDR, TA, data)
//   MDIO_IN    : serial read data from the PHY-side receiver
//   MDC        : management clock, CLK/2 while busy, 0 otherwise
//   MDIO_OUT   : serial frame bit, MSB first
//   MDIO_OE    : high while MDIO_OUT carries a driven bit
//   RD_DATA    : last completed read result
//   DATA_RDY   : one-cycle pulse when RD_DATA is updated
//   BUSY       : high from acceptance until return to IDLE
// Build option: define MDIO_PREAMBLE_EN to send 32 preamble ones first.
module mdio_controller
  import mdio_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MDIO_START,
  input  logic [FRAME_W-1:0] T_DATA,
  input  logic              MDIO_IN,
  output logic              MDC,
  output logic              MDIO_OUT,
  output logic              MDIO_OE,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              DATA_RDY,
  output logic              BUSY
);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [FRAME_W-1:0]  tx_reg, tx_next;
  // Holds the first 15 samples; the 16th goes straight into RD_DATA with them.
  logic [DATA_W-2:0]   rx_reg, rx_next;
  logic                write_reg, write_next;
  logic                out_reg, out_next;
  logic                oe_reg, oe_next;
  logic                busy_reg, busy_next;
  logic                rdy_reg, rdy_next;
  logic [DATA_W-1:0]   rd_data_reg, rd_data_next;

  logic mdc_en, mdc_rise, mdc_fall;

  // DONE is the one busy cycle where MDC must stay low.
  assign mdc_en = busy_reg && (state_reg != ST_DONE);

  mdio_clk_gen u_clk_gen (
    .clk      (CLK),
    .reset    (RESET),
    .en       (mdc_en),
    .mdc      (MDC),
    .mdc_rise (mdc_rise),
    .mdc_fall (mdc_fall)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      tx_reg    <= '0;
      rx_reg    <= '0;
      write_reg <= 1'b0;
      out_reg   <= 1'b0;
      oe_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      rdy_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tx_reg    <= tx_next;
      rx_reg    <= rx_next;
      write_reg <= write_next;
      out_reg   <= out_next;
      oe_reg    <= oe_next;
      busy_reg  <= busy_next;
      rdy_reg   <= rdy_next;
    end
  end

  // A reset that lands on a frame in flight keeps the last good read result;
  // a reset seen while idle (power-up, or held more than one cycle) clears it.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (!busy_reg) begin
        rd_data_reg <= '0;
      end
    end else begin
      rd_data_reg <= rd_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    write_next   = write_reg;
    out_next     = out_reg;
    oe_next      = oe_reg;
    busy_next    = busy_reg;
    rdy_next     = 1'b0;
    rd_data_next = rd_data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (MDIO_START) begin
          // The acceptance edge also launches the first bit, acting as the
          // opening falling edge of the MDC train.
          write_next = (T_DATA[OP_HI:OP_LO] == OP_WRITE);
          busy_next  = 1'b1;
          oe_next    = 1'b1;
`ifdef MDIO_PREAMBLE_EN
          state_next = ST_PREAMBLE;
          tx_next    = T_DATA;
          out_next   = 1'b1;
          cnt_next   = CNT_PRE;
`else
          state_next = ST_DRIVE;
          tx_next    = {T_DATA[FRAME_W-2:0], 1'b0};
          out_next   = T_DATA[ST_HI];
          cnt_next   = (T_DATA[OP_HI:OP_LO] == OP_WRITE) ? CNT_WRITE : CNT_HDR;
`endif
        end
      end

`ifdef MDIO_PREAMBLE_EN
      ST_PREAMBLE: begin
        if (mdc_fall) begin
          if (cnt_reg == '0) begin
            state_next = ST_DRIVE;
            out_next   = tx_reg[FRAME_W-1];
            tx_next    = {tx_reg[FRAME_W-2:0], 1'b0};
            cnt_next   = write_reg ? CNT_WRITE : CNT_HDR;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
`endif

      ST_DRIVE: begin
        if (mdc_fall) begin
          if (cnt_reg == '0) begin
            out_next = 1'b0;
            oe_next  = 1'b0;
            if (write_reg) begin
              state_next = ST_DONE;
            end else begin
              state_next = ST_TURN;
              cnt_next   = CNT_TA;
            end
          end else begin
            out_next = tx_reg[FRAME_W-1];
            tx_next  = {tx_reg[FRAME_W-2:0], 1'b0};
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end

      ST_TURN: begin
        if (mdc_fall) begin
          if (cnt_reg == '0) begin
            state_next = ST_CAPTURE;
            cnt_next   = CNT_DATA;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end

      ST_CAPTURE: begin
        if (mdc_rise) begin
          rx_next = {rx_reg[DATA_W-3:0], MDIO_IN};
          if (cnt_reg == '0) begin
            rd_data_next = {rx_reg, MDIO_IN};
            rdy_next     = 1'b1;
          end
        end
        if (mdc_fall) begin
          if (cnt_reg == '0) begin
            state_next = ST_DONE;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
        cnt_next   = '0;
        out_next   = 1'b0;
        oe_next    = 1'b0;
      end

      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
        cnt_next   = '0;
        out_next   = 1'b0;
        oe_next    = 1'b0;
      end
    endcase
  end

  assign MDIO_OUT = out_reg;
  assign MDIO_OE  = oe_reg;
  assign RD_DATA  = rd_data_reg;
  assign DATA_RDY = rdy_reg;
  assign BUSY     = busy_reg;

endmodule

// File: tb/tb_mdio_controller.sv
// tb_mdio_controller -- directed self-checking bench for mdio_controller.
// Observes the serial frame at each MDC rising edge, models a PHY that
// returns read data after turnaround, and checks frame content, OE window,
// BUSY length, DATA_RDY behaviour, reset abort and back-to-back starts.
// Honours MDIO_PREAMBLE_EN the same way the design does.
module tb_mdio_controller;

`ifdef MDIO_PREAMBLE_EN
  localparam int PRE = 32;
`else
  localparam int PRE = 0;
`endif
  localparam int BUSY_LEN = 65 + 2 * PRE;
  localparam logic [63:0] PRE_ONES = (PRE > 0) ? 64'hFFFF_FFFF_0000_0000 : 64'h0;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] t_data;
  logic        mdio_in;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic [15:0] rd_data;
  logic        data_rdy;
  logic        busy;

  mdio_controller dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .MDIO_START (start),
    .T_DATA     (t_data),
    .MDIO_IN    (mdio_in),
    .MDC        (mdc),
    .MDIO_OUT   (mdio_out),
    .MDIO_OE    (mdio_oe),
    .RD_DATA    (rd_data),
    .DATA_RDY   (data_rdy),
    .BUSY       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // PHY model: after MDC rise of period n, present the bit for period n+1.
  // Capture periods are 17..32 counted from the end of any preamble.
  int          phy_cnt;
  logic [15:0] phy_word;
  initial begin
    mdio_in  = 1'b0;
    phy_cnt  = 0;
    phy_word = 16'h0;
    forever begin
      int k;
      @(posedge mdc);
      phy_cnt++;
      k = phy_cnt - PRE;
      if (k >= 16 && k <= 31) mdio_in = phy_word[31 - k];
      else mdio_in = 1'b0;
    end
  end

  // Results of the last run_frame call.
  logic [63:0] cap_bits, cap_oe;
  int          busy_cyc, rdy_cnt, viol, start_lat;
  logic        last_mdc, last_oe;

  task automatic run_frame(input logic [31:0] t, input logic [15:0] phy, input int inject_at);
    logic prev_mdc, prev_out, prev_oe;
    cap_bits = '0;
    cap_oe   = '0;
    busy_cyc = 0;
    rdy_cnt  = 0;
    viol     = 0;
    phy_word = phy;
    phy_cnt  = 0;
    t_data   = t;
    start    = 1'b1;
    prev_mdc = mdc;
    prev_out = mdio_out;
    prev_oe  = mdio_oe;
    start_lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      start_lat++;
    end while (!busy && start_lat < 10);
    while (busy && busy_cyc < 400) begin
      busy_cyc++;
      rdy_cnt += int'(data_rdy);
      if (mdc && !prev_mdc) begin
        cap_bits = {cap_bits[62:0], mdio_out};
        cap_oe   = {cap_oe[62:0], mdio_oe};
      end
      if (busy_cyc > 1 && (mdio_out !== prev_out || mdio_oe !== prev_oe) && !(prev_mdc && !mdc))
        viol++;
      last_mdc = mdc;
      last_oe  = mdio_oe;
      prev_mdc = mdc;
      prev_out = mdio_out;
      prev_oe  = mdio_oe;
      if (busy_cyc == inject_at) begin
        start  = 1'b1;
        t_data = ~t;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    $display("txn t_data=%h busy_cyc=%0d bits=%h oe=%h rdy=%0d rd_data=%h",
             t, busy_cyc, cap_bits, cap_oe, rdy_cnt, rd_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rdy_seen;
    rst_n  = 1'b0;
    start  = 1'b0;
    t_data = 32'h0;
    repeat (4) @(negedge clk);
    chk("rst_mdc", mdc, 0);
    chk("rst_out", mdio_out, 0);
    chk("rst_oe", mdio_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", data_rdy, 0);
    chk("rst_rd_data", rd_data, 16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_mdc", mdc, 0);

    // Write frame.
    run_frame(32'h5A5A_1234, 16'h0, 0);
    chk("wr_lat", start_lat, 1);
    chk("wr_bits", cap_bits, PRE_ONES | 64'h5A5A_1234);
    chk("wr_oe", cap_oe, PRE_ONES | 64'hFFFF_FFFF);
    chk("wr_busy_len", busy_cyc, BUSY_LEN);
    chk("wr_no_rdy", rdy_cnt, 0);
    chk("wr_edge_viol", viol, 0);
    chk("wr_done_mdc", last_mdc, 0);
    chk("wr_done_oe", last_oe, 0);
    chk("wr_rd_data", rd_data, 16'h0000);

    // Read started the cycle after BUSY fell.
    run_frame(32'h6000_0000, 16'hBEEF, 0);
    chk("rd_lat", start_lat, 1);
    chk("rd_bits", cap_bits, PRE_ONES | 64'h6000_0000);
    chk("rd_oe", cap_oe, PRE_ONES | 64'hFFFC_0000);
    chk("rd_busy_len", busy_cyc, BUSY_LEN);
    chk("rd_rdy_cnt", rdy_cnt, 1);
    chk("rd_edge_viol", viol, 0);
    chk("rd_data", rd_data, 16'hBEEF);

    // Write with a second start mid-frame carrying different data.
    run_frame(32'h5123_4567, 16'h0, 30);
    chk("inj_bits", cap_bits, PRE_ONES | 64'h5123_4567);
    chk("inj_busy_len", busy_cyc, BUSY_LEN);
    chk("inj_rd_data_kept", rd_data, 16'hBEEF);
    repeat (3) @(negedge clk);
    chk("inj_no_restart", busy, 0);

    // Read aborted by reset during MDC period 20.
    phy_word = 16'h1234;
    phy_cnt  = 0;
    t_data   = 32'h6000_0000;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    n        = 0;
    rdy_seen = 0;
    while (phy_cnt < 20 && n < 200) begin
      rdy_seen += int'(data_rdy);
      @(negedge clk);
      n++;
    end
    chk("abort_reached", (n < 200), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_mdc", mdc, 0);
    chk("abort_out", mdio_out, 0);
    chk("abort_oe", mdio_oe, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdy", data_rdy, 0);
    chk("abort_rd_data", rd_data, 16'hBEEF);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      rdy_seen += int'(data_rdy);
    end
    chk("abort_no_rdy", rdy_seen, 0);
    chk("abort_idle", busy, 0);
    chk("abort_rd_data_after", rd_data, 16'hBEEF);

    // Recovery read with a different header and data.
    run_frame(32'h6A5F_0000, 16'h8001, 0);
    chk("rd2_bits", cap_bits, PRE_ONES | 64'h6A5C_0000);
    chk("rd2_oe", cap_oe, PRE_ONES | 64'hFFFC_0000);
    chk("rd2_rdy_cnt", rdy_cnt, 1);
    chk("rd2_data", rd_data, 16'h8001);

`ifdef MDIO_PREAMBLE_EN
    run_frame(32'h5000_0001, 16'h0, 0);
    chk("pre_bits", cap_bits, 64'hFFFF_FFFF_5000_0001);
    chk("pre_oe", cap_oe, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pre_busy_len", busy_cyc, 129);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdio_controller.md
MDIO_CONTROLLER -- requirements
Module: mdio_controller

Interface
REQ-001 CLK  input  1  system clock; all logic on rising edge.
REQ-002 RESET  input  1  reset, synchronous, active-low.
REQ-003 MDIO_START  input  1  one-CLK request to launch a transaction; sampled only in IDLE.
REQ-004 T_DATA  input  32  frame: [31:30] ST, [29:28] OP, [27:23] PHYADDR, [22:18] REGADDR, [17:16] TA, [15:0] write data.
REQ-005 MDIO_IN  input  1  serial read data returned by the PHY-side receiver.
REQ-006 MDC  output  1  management clock, CLK/2.
REQ-007 MDIO_OUT  output  1  serial frame bit, MSB first.
REQ-008 MDIO_OE  output  1  high while MDIO_OUT carries a valid driven bit.
REQ-009 RD_DATA  output  16  data captured from MDIO_IN in a read.
REQ-010 DATA_RDY  output  1  one-CLK pulse when RD_DATA is updated.
REQ-011 BUSY  output  1  high from request acceptance until return to IDLE.

Function
REQ-012 MDC SHALL toggle every CLK while BUSY and SHALL be held 0 in IDLE; one MDC period = 2 CLK.
REQ-013 MDIO_OUT/MDIO_OE SHALL change only on the CLK edge where MDC goes 1->0; MDIO_IN SHALL be sampled only on the edge where MDC goes 0->1.
REQ-014 States: IDLE, PREAMBLE (only with macro), DRIVE, TURN, CAPTURE, DONE.
REQ-015 IDLE + MDIO_START=1: latch T_DATA, BUSY=1 next cycle, enter PREAMBLE or DRIVE; MDIO_START during BUSY SHALL be ignored.
REQ-016 Write (latched OP=2'b01): DRIVE emits all 32 bits, T_DATA[31] first, MDIO_OE=1 for 32 MDC periods, then DONE.
REQ-017 Read (any other OP): DRIVE emits bits [31:18] (14 bits), TURN holds MDIO_OE=0 and MDIO_OUT=0 for 2 MDC periods, CAPTURE samples 16 bits MSB first into a shift register with MDIO_OE=0.
REQ-018 After the 16th sample, RD_DATA SHALL load the shift register and DATA_RDY SHALL pulse for exactly one CLK in the same cycle.
REQ-019 RD_DATA SHALL hold its value until the next completed read; writes SHALL NOT change it or pulse DATA_RDY.
REQ-020 DONE lasts one CLK with MDC=0 and MDIO_OE=0; then IDLE, BUSY=0.
REQ-021 Frame length excluding preamble: 32 MDC periods (64 CLK) for both reads and writes; a new MDIO_START is accepted the CLK after BUSY falls.
REQ-022 Bit counter 6 bits, counts down, no wrap beyond a state's terminal count.

Reset
REQ-023 RESET=0 at a CLK edge SHALL force IDLE regardless of state, aborting any frame mid-bit.
REQ-024 Reset values: MDC=0, MDIO_OUT=0, MDIO_OE=0, RD_DATA=16'h0000, DATA_RDY=0, BUSY=0, counter=0.
REQ-025 An aborted read SHALL NOT update RD_DATA or pulse DATA_RDY.

Configuration
REQ-026 Macro MDIO_PREAMBLE_EN defined: PREAMBLE state drives 32 ones with MDIO_OE=1 (32 MDC periods) before DRIVE; frame adds 64 CLK.
REQ-027 Macro undefined: no PREAMBLE state; DRIVE begins the cycle after acceptance.

Structure
REQ-028 Shared package mdio_pkg SHALL hold state encodings, OP codes (OP_WRITE=2'b01), field bit positions, frame/data widths.
REQ-029 MDC generation and edge strobes SHALL be in sub-module mdio_clk_gen (outputs MDC, rise/fall strobes; enable input from BUSY).

Verification
REQ-030 Write T_DATA=32'h5A5A_1234, pulse MDIO_START -> MDIO_OUT serial equals 0x5A5A1234 MSB first, MDIO_OE=1 for 32 MDC, no DATA_RDY, BUSY falls after DONE.
REQ-031 Read T_DATA=32'h6000_0000 with PHY model driving 16'hBEEF after TA -> MDIO_OE=0 for TA+16 bits, RD_DATA=16'hBEEF, one-CLK DATA_RDY.
REQ-032 MDIO_START pulsed again mid-frame with different T_DATA -> ignored; serialized frame unchanged.
REQ-033 RESET=0 at MDC period 20 of a read -> all outputs to reset values next CLK, RD_DATA retains prior value, no DATA_RDY.
REQ-034 Back-to-back: write then read started the CLK after BUSY falls -> both frames correct, no gap cycle lost.
REQ-035 With MDIO_PREAMBLE_EN: write 32'h5000_0001 -> 32 ones with OE=1 precede frame; total BUSY = 128 CLK + DONE.
